// File: rtl/snes_clk_gen_if.sv
// Control and timebase bundle for snes_clk_gen: soft reset / pause requests in,
// master-clock enables, phase index and core reset out.
interface snes_clk_gen_if;
  logic       soft_reset;
  logic       pause;
  logic       mclk_ce;
  logic [1:0] mclk_phase;
  logic       dot_ce;
  logic       core_resetn;

  modport master (
    input  soft_reset,
    input  pause,
    output mclk_ce,
    output mclk_phase,
    output dot_ce,
    output core_resetn
  );

  modport slave (
    output soft_reset,
    output pause,
    input  mclk_ce,
    input  mclk_phase,
    input  dot_ce,
    input  core_resetn
  );
endinterface

// File: rtl/snes_clk_gen.sv
// SNES master-clock timebase: mclk/dot clock enables, phase index and core reset
// sequencer in the 86.4 MHz domain. Define SNES_CLK_NCO_EN for the NTSC-exact NCO divider.
module snes_clk_gen #(
  parameter int unsigned RESET_CYCLES = 1024,
  parameter logic [31:0] NCO_STEP     = 32'd1067641024
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  snes_clk_gen_if.master     io_bus
);

  localparam logic [15:0] RC_LIMIT = 16'(RESET_CYCLES);

  logic [1:0]  r_phase;
  logic        r_mclk_ce;
  logic [1:0]  r_dot;
  logic        r_dot_ce;
  logic [15:0] r_hold;
  logic        r_core_resetn;

  logic        w_hold;
  logic        w_wrap;
  logic [1:0]  w_phase_nxt;
  logic        w_ce_nxt;

  // Pause only bites on a master-cycle boundary so a cycle in flight completes.
  assign w_hold = io_bus.pause && (r_phase == 2'd0);

`ifdef SNES_CLK_NCO_EN
  logic [31:0] r_acc;
  logic [32:0] w_acc_sum;

  assign w_acc_sum   = {1'b0, r_acc} + {1'b0, NCO_STEP};
  assign w_wrap      = w_acc_sum[32];
  assign w_phase_nxt = w_wrap ? 2'd0 : ((r_phase == 2'd3) ? 2'd3 : r_phase + 2'd1);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_acc <= 32'd0;
    end else if (!w_hold) begin
      r_acc <= w_acc_sum[31:0];
    end
  end
`else
  logic w_unused_nco;

  assign w_unused_nco = ^NCO_STEP;
  assign w_wrap       = (r_phase == 2'd3);
  assign w_phase_nxt  = r_phase + 2'd1;
`endif

  assign w_ce_nxt = !w_hold && w_wrap;

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_phase   <= 2'd0;
      r_mclk_ce <= 1'b0;
      r_dot     <= 2'd0;
      r_dot_ce  <= 1'b0;
    end else begin
      r_mclk_ce <= w_ce_nxt;
      r_dot_ce  <= w_ce_nxt && (r_dot == 2'd3);
      if (!w_hold) begin
        r_phase <= w_phase_nxt;
      end
      if (w_ce_nxt) begin
        r_dot <= r_dot + 2'd1;
      end
    end
  end

  // Hold counter advances with the edge that raises mclk_ce, so the release
  // lands one edge after the RESET_CYCLES-th pulse.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_hold        <= 16'd0;
      r_core_resetn <= 1'b0;
    end else if (io_bus.soft_reset) begin
      r_hold        <= 16'd0;
      r_core_resetn <= 1'b0;
    end else if (!r_core_resetn) begin
      if (r_hold == RC_LIMIT) begin
        r_core_resetn <= 1'b1;
      end else if (w_ce_nxt) begin
        r_hold <= r_hold + 16'd1;
      end
    end
  end

  assign io_bus.mclk_ce     = r_mclk_ce;
  assign io_bus.mclk_phase  = r_phase;
  assign io_bus.dot_ce      = r_dot_ce;
  assign io_bus.core_resetn = r_core_resetn;

endmodule

// File: tb/tb_snes_clk_gen.sv
// Directed self-checking bench for snes_clk_gen with RESET_CYCLES = 16.
module tb_snes_clk_gen;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;
  int   edge_n;

  snes_clk_gen_if u_bus ();

  snes_clk_gen #(
    .RESET_CYCLES(16)
  ) dut (
    .i_clk   (clk),
    .i_resetn(resetn),
    .io_bus  (u_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic test_reset();
    resetn           = 1'b0;
    u_bus.soft_reset = 1'b0;
    u_bus.pause      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (u_bus.mclk_ce !== 1'b0) begin
      n_fail++; $display("FAIL reset_mclk_ce got %b exp 0", u_bus.mclk_ce);
    end
    n_tests++;
    if (u_bus.mclk_phase !== 2'd0) begin
      n_fail++; $display("FAIL reset_phase got %0d exp 0", u_bus.mclk_phase);
    end
    n_tests++;
    if (u_bus.dot_ce !== 1'b0) begin
      n_fail++; $display("FAIL reset_dot_ce got %b exp 0", u_bus.dot_ce);
    end
    n_tests++;
    if (u_bus.core_resetn !== 1'b0) begin
      n_fail++; $display("FAIL reset_core_resetn got %b exp 0", u_bus.core_resetn);
    end
    @(negedge clk);
    resetn = 1'b1;
    edge_n = 0;
  endtask

  // Edges 1..200 after release: phase = k mod 4, ce on k%4==0, dot on k%16==0,
  // core_resetn rises at edge 65.
  task automatic test_divider();
    for (int k = 1; k <= 200; k++) begin
      step();
      n_tests++;
      if (u_bus.mclk_phase !== 2'(k % 4)) begin
        n_fail++; $display("FAIL div_phase edge %0d got %0d exp %0d", k, u_bus.mclk_phase, k % 4);
      end
      if (k <= 70) begin
        n_tests++;
        if (u_bus.mclk_ce !== ((k % 4) == 0)) begin
          n_fail++; $display("FAIL div_mclk_ce edge %0d got %b exp %b", k, u_bus.mclk_ce, (k % 4) == 0);
        end
        n_tests++;
        if (u_bus.dot_ce !== ((k % 16) == 0)) begin
          n_fail++; $display("FAIL div_dot_ce edge %0d got %b exp %b", k, u_bus.dot_ce, (k % 16) == 0);
        end
        n_tests++;
        if (u_bus.core_resetn !== (k >= 65)) begin
          n_fail++; $display("FAIL div_core_resetn edge %0d got %b exp %b", k, u_bus.core_resetn, k >= 65);
        end
      end
    end
  endtask

  // Pulse sampled at edge 201; 16th mclk_ce afterwards is at edge 264, release at 265.
  task automatic test_soft_reset();
    u_bus.soft_reset = 1'b1;
    step();
    u_bus.soft_reset = 1'b0;
    n_tests++;
    if (u_bus.core_resetn !== 1'b0) begin
      n_fail++; $display("FAIL soft_core_low edge %0d got %b exp 0", edge_n, u_bus.core_resetn);
    end
    while (edge_n < 270) begin
      step();
      n_tests++;
      if (u_bus.mclk_phase !== 2'(edge_n % 4)) begin
        n_fail++; $display("FAIL soft_phase edge %0d got %0d exp %0d", edge_n, u_bus.mclk_phase, edge_n % 4);
      end
      n_tests++;
      if (u_bus.core_resetn !== (edge_n >= 265)) begin
        n_fail++; $display("FAIL soft_core_resetn edge %0d got %b exp %b", edge_n, u_bus.core_resetn, edge_n >= 265);
      end
    end
  endtask

  // Edge 270 leaves phase 2; pause completes the cycle, holds 8 edges, then resumes.
  task automatic test_pause();
    int eff;
    u_bus.pause = 1'b1;
    step();
    n_tests++;
    if (u_bus.mclk_phase !== 2'd3 || u_bus.mclk_ce !== 1'b0) begin
      n_fail++; $display("FAIL pause_finish3 got phase %0d ce %b exp 3/0", u_bus.mclk_phase, u_bus.mclk_ce);
    end
    step();
    n_tests++;
    if (u_bus.mclk_phase !== 2'd0 || u_bus.mclk_ce !== 1'b1 || u_bus.dot_ce !== 1'b1) begin
      n_fail++; $display("FAIL pause_wrap got phase %0d ce %b dot %b exp 0/1/1",
                         u_bus.mclk_phase, u_bus.mclk_ce, u_bus.dot_ce);
    end
    repeat (8) begin
      step();
      n_tests++;
      if (u_bus.mclk_phase !== 2'd0 || u_bus.mclk_ce !== 1'b0 || u_bus.dot_ce !== 1'b0) begin
        n_fail++; $display("FAIL pause_hold edge %0d got phase %0d ce %b dot %b exp 0/0/0",
                           edge_n, u_bus.mclk_phase, u_bus.mclk_ce, u_bus.dot_ce);
      end
    end
    u_bus.pause = 1'b0;
    while (edge_n < 300) begin
      step();
      eff = edge_n - 8;
      n_tests++;
      if (u_bus.mclk_phase !== 2'(eff % 4) || u_bus.mclk_ce !== ((eff % 4) == 0) ||
          u_bus.dot_ce !== ((eff % 16) == 0)) begin
        n_fail++; $display("FAIL pause_resume edge %0d got phase %0d ce %b dot %b exp %0d/%b/%b",
                           edge_n, u_bus.mclk_phase, u_bus.mclk_ce, u_bus.dot_ce,
                           eff % 4, (eff % 4) == 0, (eff % 16) == 0);
      end
    end
  endtask

  task automatic test_soft_reset_pause();
    int  guard;
    logic bad;
    guard = 0;
    while (u_bus.mclk_phase !== 2'd0 && guard < 8) begin
      step();
      guard++;
    end
    n_tests++;
    if (u_bus.mclk_phase !== 2'd0) begin
      n_fail++; $display("FAIL srp_find_phase0 got %0d exp 0", u_bus.mclk_phase);
    end
    u_bus.pause      = 1'b1;
    u_bus.soft_reset = 1'b1;
    step();
    u_bus.soft_reset = 1'b0;
    n_tests++;
    if (u_bus.core_resetn !== 1'b0 || u_bus.mclk_phase !== 2'd0) begin
      n_fail++; $display("FAIL srp_enter got core %b phase %0d exp 0/0", u_bus.core_resetn, u_bus.mclk_phase);
    end
    bad = 1'b0;
    repeat (100) begin
      step();
      if (u_bus.core_resetn !== 1'b0 || u_bus.mclk_ce !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++; $display("FAIL srp_held got activity %b exp 0", bad);
    end
    u_bus.pause = 1'b0;
    for (int j = 1; j <= 66; j++) begin
      step();
      n_tests++;
      if (u_bus.mclk_ce !== ((j % 4) == 0)) begin
        n_fail++; $display("FAIL srp_ce j %0d got %b exp %b", j, u_bus.mclk_ce, (j % 4) == 0);
      end
      if (j >= 63) begin
        n_tests++;
        if (u_bus.core_resetn !== (j >= 65)) begin
          n_fail++; $display("FAIL srp_core_resetn j %0d got %b exp %b", j, u_bus.core_resetn, j >= 65);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int cnt;
    int guard;
    cnt   = 0;
    guard = 0;
    while (!(cnt == 3 && u_bus.mclk_phase == 2'd2) && guard < 80) begin
      step();
      guard++;
      if (u_bus.dot_ce === 1'b1) cnt = 0;
      else if (u_bus.mclk_ce === 1'b1) cnt++;
    end
    n_tests++;
    if (!(cnt == 3 && u_bus.mclk_phase == 2'd2)) begin
      n_fail++; $display("FAIL async_setup got cnt %0d phase %0d exp 3/2", cnt, u_bus.mclk_phase);
    end
    n_tests++;
    if (u_bus.core_resetn !== 1'b1) begin
      n_fail++; $display("FAIL async_pre_core got %b exp 1", u_bus.core_resetn);
    end
    #2;
    resetn = 1'b0;
    #1;
    n_tests++;
    if (u_bus.mclk_phase !== 2'd0 || u_bus.mclk_ce !== 1'b0 ||
        u_bus.dot_ce !== 1'b0 || u_bus.core_resetn !== 1'b0) begin
      n_fail++; $display("FAIL async_clear got phase %0d ce %b dot %b core %b exp 0/0/0/0",
                         u_bus.mclk_phase, u_bus.mclk_ce, u_bus.dot_ce, u_bus.core_resetn);
    end
    @(negedge clk);
    resetn = 1'b1;
    edge_n = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      n_tests++;
      if (u_bus.mclk_phase !== 2'(k % 4) || u_bus.dot_ce !== ((k % 16) == 0) ||
          u_bus.core_resetn !== 1'b0) begin
        n_fail++; $display("FAIL async_restart edge %0d got phase %0d dot %b core %b exp %0d/%b/0",
                           k, u_bus.mclk_phase, u_bus.dot_ce, u_bus.core_resetn,
                           k % 4, (k % 16) == 0);
      end
    end
  endtask

`ifdef SNES_CLK_NCO_EN
  task automatic test_nco();
    int n_ce;
    int n_dot;
    int last;
    int bad_gap;
    n_ce    = 0;
    n_dot   = 0;
    last    = -1;
    bad_gap = 0;
    for (int k = 1; k <= 86400; k++) begin
      step();
      if (u_bus.mclk_ce === 1'b1) begin
        if (last >= 0 && (k - last) != 4 && (k - last) != 5) bad_gap++;
        last = k;
        n_ce++;
      end
      if (u_bus.dot_ce === 1'b1) n_dot++;
    end
    n_tests++;
    if (n_ce < 21476 || n_ce > 21478) begin
      n_fail++; $display("FAIL nco_ce_count got %0d exp 21477+-1", n_ce);
    end
    n_tests++;
    if (bad_gap != 0) begin
      n_fail++; $display("FAIL nco_spacing got %0d bad gaps exp 0", bad_gap);
    end
    n_tests++;
    if (n_dot < n_ce / 4 - 1 || n_dot > n_ce / 4 + 1) begin
      n_fail++; $display("FAIL nco_dot_count got %0d exp %0d+-1", n_dot, n_ce / 4);
    end
  endtask
`endif

  initial begin
    n_tests = 0;
    n_fail  = 0;
    edge_n  = 0;
    test_reset();
`ifdef SNES_CLK_NCO_EN
    test_nco();
`else
    test_divider();
    test_soft_reset();
    test_pause();
    test_soft_reset_pause();
    test_async_reset();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snes_clk_gen.md
# snes_clk_gen

Generates the SNES master-clock timebase inside the 86.4 MHz fast-clock domain produced by the PLL (27 MHz × 32 / 10). It produces single-cycle master-clock enables (nominally ÷4, about 21.6 MHz), a 2-bit phase index for sub-cycle scheduling of SDRAM and core work, and a PPU dot enable (÷16, about 5.4 MHz). It also runs a core reset sequencer, so every SNES core block runs on `clk` with clock enables rather than on derived clocks.

## Interface
- `RESET_CYCLES`, default 1024: number of `mclk_ce` pulses `core_resetn` stays low after reset or `soft_reset`; range 1..65535.
- `NCO_STEP`, default 32'd1067641024: phase increment per `clk` (≈ 2^32 × 21.477272/86.4). Used only with `SNES_CLK_NCO_EN`.
- `clk` in 1: 86.4 MHz fast clock (PLL CLKOUT1).
- `resetn` in 1: asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to `clk`.
- `soft_reset` in 1: synchronous, active-high; restarts the core reset hold.
- `pause` in 1: synchronous, active-high; freezes the timebase at a master-cycle boundary.
- `mclk_ce` out 1: one-`clk` pulse marking the start of a master cycle.
- `mclk_phase` out 2: index of the current `clk` within the master cycle.
- `dot_ce` out 1: one-`clk` pulse on every 4th `mclk_ce`, coincident with it.
- `core_resetn` out 1: active-low reset for the SNES core, synchronous to `clk`.

## Operation
- All outputs are registered.
- Reset values: `mclk_ce`=0, `mclk_phase`=0, `dot_ce`=0, `core_resetn`=0. Internal dot counter, hold counter and NCO accumulator all reset to 0.
- Fixed divider (no macro):
  - `mclk_phase` counts 0,1,2,3,0,…
  - `mclk_ce`=1 exactly in the cycles where `mclk_phase` has just wrapped 3→0.
- Dot counter (2 bits):
  - Increments on each `mclk_ce`.
  - `dot_ce`=1 together with the `mclk_ce` that wraps it 3→0.
- Pause:
  - When `pause`=1 and `mclk_phase`=0, the phase, dot counter and accumulator hold.
  - No `mclk_ce`/`dot_ce` pulses while held.
  - A master cycle already in progress (phase 1..3) completes before the hold takes effect.
  - Release resumes counting on the next edge.
- Reset sequencer:
  - The hold counter (16 bits) increments on each `mclk_ce` while `core_resetn`=0.
  - When it reaches `RESET_CYCLES`, `core_resetn` rises on the following edge and the counter stops.
  - `soft_reset`=1 clears the hold counter and drives `core_resetn`=0 on the next edge, regardless of state.
  - `soft_reset` does not disturb `mclk_phase`, the dot counter or the accumulator.
  - `soft_reset` held high keeps `core_resetn` low; counting starts after it drops.
  - `soft_reset` during pause keeps `core_resetn` low until pulses resume and `RESET_CYCLES` more `mclk_ce` pulses have occurred.
- Async `resetn` assertion mid-operation returns all state to reset values immediately.

## Timing
- Fixed mode, edges numbered from the first rising edge after `resetn` release (edge 1):
  - `mclk_phase`=k mod 4.
  - `mclk_ce` is high after edges 4, 8, 12, …
  - First `dot_ce` is after edge 16.
- `core_resetn` rises one edge after the `RESET_CYCLES`-th `mclk_ce`. In fixed mode that is edge 4×`RESET_CYCLES`+1.
- Latency:
  - `soft_reset` to `core_resetn` low: 1 edge.
  - `pause` release to next counting: 1 edge.

## Configuration
- `SNES_CLK_NCO_EN` defined:
  - The master-cycle boundary comes from a 32-bit accumulator: `acc += NCO_STEP` on each unpaused edge.
  - Carry out of bit 31 sets `mclk_phase`=0 and `mclk_ce`=1 on that edge.
  - Otherwise `mclk_phase` increments, saturating at 3.
  - Master cycles are therefore 4 or 5 `clk` long, averaging 21.477 MHz (NTSC-exact).
  - Pause condition, dot counter and reset sequencer are unchanged.
- Undefined: fixed ÷4 divider as described above; the accumulator is not built.

## Test plan
- Reset release, fixed mode, `RESET_CYCLES`=16:
  - `mclk_ce` first after edge 4, then every 4 edges.
  - `dot_ce` after edges 16, 32, …
  - `core_resetn` rises after edge 65.
- `soft_reset` pulse at edge 200 (`core_resetn` already high):
  - `core_resetn` low after edge 201.
  - Rises again 16 `mclk_ce` pulses later.
  - Phase sequence unbroken.
- `pause` asserted at phase 2:
  - Phase advances 3→0 with an `mclk_ce`, then holds at 0 with no pulses.
  - Release gives phase 1 on the next edge.
- `soft_reset` during pause:
  - `core_resetn` stays low indefinitely while paused.
  - Rises 16 `mclk_ce` after release.
- Async `resetn` low mid-cycle at phase 2, dot counter 3: all outputs 0 immediately, no clock edge required.
- `SNES_CLK_NCO_EN`, default `NCO_STEP`, 86400 edges:
  - 21477±1 `mclk_ce` pulses.
  - Every spacing 4 or 5.
  - `dot_ce` count = `mclk_ce` count / 4 ± 1.
